// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator side of the 8-bit ALU operand/result interface. Commands are
//   queued in a small FIFO, issued one at a time onto registered ALU operand
//   and select lines, held for SETTLE cycles, and the ALU outputs are then
//   captured into a response register offered on a valid/ready channel.
//   A command may take its carry-in from the last captured overflow (chain)
//   to build multi-byte arithmetic.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command channel (cmd_ready = FIFO not full)
//   cmd_a, cmd_b             operands
//   cmd_op                   {Op,S1,S0} function select
//   cmd_cin, cmd_chain       explicit carry-in / use last overflow instead
//   alu_a, alu_b, alu_op,
//   alu_s1, alu_s0, alu_cin  registered drive into the ALU
//   alu_result, alu_overflow,
//   alu_remainder            ALU outputs, captured after the settle time
//   rsp_valid/rsp_ready      response channel
//   rsp_result, rsp_overflow,
//   rsp_remainder, rsp_op    captured response and the op it belongs to
//   cmd_count                FIFO occupancy
//   busy                     command in flight or queued
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_a,
  input  logic [7:0]                   cmd_b,
  input  logic [2:0]                   cmd_op,
  input  logic                         cmd_cin,
  input  logic                         cmd_chain,
  output logic [7:0]                   alu_a,
  output logic [7:0]                   alu_b,
  output logic                         alu_op,
  output logic                         alu_s1,
  output logic                         alu_s0,
  output logic                         alu_cin,
  input  logic [7:0]                   alu_result,
  input  logic                         alu_overflow,
  input  logic [7:0]                   alu_remainder,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [7:0]                   rsp_result,
  output logic                         rsp_overflow,
  output logic [7:0]                   rsp_remainder,
  output logic [2:0]                   rsp_op,
  output logic [$clog2(DEPTH+1)-1:0]   cmd_count,
  output logic                         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       cin;
    logic       chain;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // ---------------- command FIFO ----------------
  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;
  cmd_t          head;

  state_e        state_q, state_d;

  // Ready depends only on the registered count, so a full FIFO refuses a
  // push even in the cycle it pops.
  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, op: cmd_op, cin: cmd_cin, chain: cmd_chain};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- sequencer FSM ----------------
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0] alu_sel_q, alu_sel_d;
  logic       alu_cin_q, alu_cin_d;
  logic       last_ovf_q, last_ovf_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_result_q, rsp_result_d;
  logic       rsp_ovf_q, rsp_ovf_d;
  logic [7:0] rsp_rem_q, rsp_rem_d;
  logic [2:0] rsp_op_q, rsp_op_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_cin_d    = alu_cin_q;
    last_ovf_d   = last_ovf_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_op_d     = rsp_op_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          alu_a_d   = head.a;
          alu_b_d   = head.b;
          alu_sel_d = head.op;
          alu_cin_d = head.chain ? last_ovf_q : head.cin;
          cnt_d     = 4'(SETTLE - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_ovf_d    = alu_overflow;
          rsp_rem_d    = alu_remainder;
          rsp_op_d     = alu_sel_q;
          last_ovf_d   = alu_overflow;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_cin_q    <= 1'b0;
      last_ovf_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_rem_q    <= '0;
      rsp_op_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_cin_q    <= alu_cin_d;
      last_ovf_q   <= last_ovf_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_op_q     <= rsp_op_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_sel_q[2];
  assign alu_s1        = alu_sel_q[1];
  assign alu_s0        = alu_sel_q[0];
  assign alu_cin       = alu_cin_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_op        = rsp_op_q;
  assign cmd_count     = count_q;
  assign busy          = (state_q != IDLE) || (count_q != '0);

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 8-bit ALU operand/result interface.
- Accepts queued ALU commands over a valid/ready channel and drives registered operand and select lines into the ALU.
- Holds those lines for a fixed settle time, then captures Result, Overflow_flag and Remainder into a response register presented on a valid/ready channel.
- Optionally chains the previous overflow into the next command's carry-in, for multi-byte arithmetic.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of 2, minimum 2.
- SETTLE, 1, cycles the ALU inputs are held before capture; legal range 1..15.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full, with no same-cycle pop bypass.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_op  in  3  {Op,S1,S0} function select, passed through unchanged.
- cmd_cin  in  1  explicit carry-in.
- cmd_chain  in  1  1 = use last captured overflow as carry-in, ignoring cmd_cin.
- alu_a, alu_b  out  8 each  registered operands to the ALU.
- alu_op, alu_s1, alu_s0, alu_cin  out  1 each  registered selects and carry to the ALU.
- alu_result  in  8  ALU Result.
- alu_overflow  in  1  ALU Overflow_flag.
- alu_remainder  in  8  ALU Remainder.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_result  out  8  captured result.
- rsp_overflow  out  1  captured overflow.
- rsp_remainder  out  8  captured remainder.
- rsp_op  out  3  cmd_op of the command this response belongs to.
- cmd_count  out  clog2(DEPTH+1)  FIFO occupancy.
- busy  out  1  state!=IDLE or cmd_count!=0.

Behaviour:
- Reset (synchronous, active-high, one clock):
  - state=IDLE; FIFO emptied (cmd_count=0).
  - All alu_* outputs 0; all rsp_* outputs 0; rsp_valid=0.
  - last_ovf=0; settle counter 0.
  - Reset mid-operation discards the in-flight command and all queued commands; no response is ever produced for them.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - Pop only on the IDLE->WAIT transition.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, cmd_ready=0 even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH; strict FIFO order.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if cmd_count!=0, pop the head, load alu_a/alu_b/alu_op/alu_s1/alu_s0 and alu_cin (= cmd_chain ? last_ovf : cmd_cin), load counter=SETTLE-1, go to WAIT. Otherwise stay.
  - WAIT: if counter==0, capture alu_result/alu_overflow/alu_remainder into rsp_*, set rsp_op, set last_ovf=alu_overflow, set rsp_valid=1, go to RESP. Otherwise decrement the counter.
  - RESP: hold rsp_* stable while rsp_valid&&!rsp_ready. On rsp_ready, clear rsp_valid and go to IDLE. rsp_* data keeps its value after the handshake.
- alu_* outputs change only on the IDLE->WAIT load. They stay stable through WAIT, RESP and the following IDLE.
- Latency: command accepted in cycle n, with FIFO empty and state IDLE:
  - alu_* updated in cycle n+2.
  - rsp_valid high in cycle n+2+SETTLE.
- Throughput: with rsp_ready tied high, one response per SETTLE+2 cycles.
- rsp_valid never drops without a handshake, and no command executes while a response is pending.
- chain with no prior capture since reset uses last_ovf=0.

Test Plan:
Bench ALU stub: result=(a+b+cin)[7:0], overflow=carry-out, remainder=a^b, driven combinationally from alu_*.
1. Single command. SETTLE=1; accept a=0x12, b=0x34, op=000, cin=0, chain=0 in cycle 0 -> alu_a=0x12 and alu_b=0x34 in cycle 2; rsp_valid=1 in cycle 3 with result 0x46, overflow 0, remainder 0x26, rsp_op 000.
2. Chaining. cmd1 a=0xFF, b=0x01, cin=0 -> result 0x00, overflow 1. cmd2 a=0x10, b=0x20, cin=0, chain=1 -> alu_cin=1, result 0x31, overflow 0.
3. Full FIFO. DEPTH=4, rsp_ready=0, cmd_valid held high with 6 distinct commands -> exactly 5 accepted, cmd_ready=0, cmd_count=4. Raise rsp_ready -> 5 responses in acceptance order, none lost or duplicated; the 6th is then accepted.
4. Response backpressure. Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_* and alu_* all constant, no pop, cmd_count unchanged.
5. Reset mid-operation. Assert rst for 1 cycle during WAIT with 3 commands queued -> next cycle rsp_valid=0, cmd_count=0, busy=0, alu_*=0. A following chain=1 command a=0x01, b=0x01 gives result 0x02 (last_ovf cleared).
6. Settle latency. SETTLE=3; a=0x80, b=0x80 accepted in cycle 0 -> rsp_valid first high in cycle 5 with result 0x00, overflow 1. Back-to-back commands with rsp_ready=1 give a 5-cycle response spacing.
